// File: rtl/poly_small_norm_check_pkg.sv
// ---------------------------------------------------------------------------
// poly_small_norm_check_pkg
// Shared Falcon keygen definitions: collector FSM state encoding, the joint
// squared-norm acceptance bound, datapath widths and the per-degree
// coefficient bit budget.
// ---------------------------------------------------------------------------
package poly_small_norm_check_pkg;

  // Collector FSM states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_FINISH  = 2'd2
  } state_t;

  // Accept requires ||f||^2 + ||g||^2 strictly below this value
  localparam int unsigned FALCON_NORM_BOUND = 16823;

  localparam int unsigned COEFF_W = 8;   // signed sampler coefficient
  localparam int unsigned SQ_W    = 16;  // square of an 8-bit magnitude
  localparam int unsigned ACC_W   = 32;  // joint norm accumulator

  // Coefficient bit budget: 6 bits for FALCON512, 5 bits for FALCON1024
  function automatic int unsigned max_fg_bits(input int unsigned logn);
    return (logn >= 32'd10) ? 32'd5 : 32'd6;
  endfunction

endpackage

// File: rtl/poly_small_norm_check_sq_range.sv
// ---------------------------------------------------------------------------
// poly_coeff_sq_range
// Registered square-and-range stage for one signed coefficient.
//   clk, rst      : clock, asynchronous active-high reset
//   i_valid       : coefficient accepted this cycle
//   i_coeff       : signed 8-bit coefficient
//   o_valid       : registered i_valid
//   o_sq          : unsigned square of the coefficient (held when idle)
//   o_range_bad   : |coeff| exceeds 2^(MAX_BITS-1)-1
// ---------------------------------------------------------------------------
module poly_coeff_sq_range
  import poly_small_norm_check_pkg::*;
#(
  parameter int unsigned MAX_BITS = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_valid,
  input  logic [COEFF_W-1:0] i_coeff,
  output logic               o_valid,
  output logic [SQ_W-1:0]    o_sq,
  output logic               o_range_bad
);

  localparam int unsigned MAG_LIM = (32'd1 << (MAX_BITS - 32'd1)) - 32'd1;

  logic [COEFF_W-1:0] w_mag;
  logic [SQ_W-1:0]    w_sq;
  logic               w_bad;

  // Magnitude as 8-bit unsigned: -128 becomes 128 and fails the range check
  assign w_mag = i_coeff[COEFF_W-1] ? (COEFF_W'(~i_coeff) + COEFF_W'(1)) : i_coeff;
  assign w_sq  = SQ_W'(w_mag) * SQ_W'(w_mag);
  assign w_bad = (w_mag > COEFF_W'(MAG_LIM));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid     <= 1'b0;
      o_sq        <= '0;
      o_range_bad <= 1'b0;
    end else begin
      o_valid <= i_valid;
      if (i_valid) begin
        o_sq        <= w_sq;
        o_range_bad <= w_bad;
      end
    end
  end

endmodule

// File: rtl/poly_small_norm_check.sv
// ---------------------------------------------------------------------------
// poly_small_norm_check
// Collects 2n signed coefficients (f then g) from the small-Gaussian
// sampler, writes each to the keygen buffer RAM, range-checks each one and
// accumulates the joint squared norm, then issues one accept/reject verdict.
//   clk, rst   : clock, asynchronous active-high reset
//   start      : begin a new f/g pair (IDLE only)
//   abort      : abandon current pair, back to IDLE without a verdict
//   f_valid, f : coefficient strobe and signed value (no backpressure)
//   gen_ena    : sampler enable, high while collecting
//   buf_we, buf_addr, buf_wdata : buffer RAM write port (f at 0..n-1, g at n..2n-1)
//   busy       : collecting or draining
//   done       : one-cycle verdict pulse
//   ok, range_err, norm_sq : verdict, held until next start
// ---------------------------------------------------------------------------
module poly_small_norm_check
  import poly_small_norm_check_pkg::*;
#(
  parameter int unsigned LOGN       = 9,
  parameter int unsigned MAX_BITS   = max_fg_bits(LOGN),
  parameter int unsigned NORM_BOUND = FALCON_NORM_BOUND
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               f_valid,
  input  logic [COEFF_W-1:0] f,
  output logic               gen_ena,
  output logic               buf_we,
  output logic [LOGN:0]      buf_addr,
  output logic [COEFF_W-1:0] buf_wdata,
  output logic               busy,
  output logic               done,
  output logic               ok,
  output logic               range_err,
  output logic [ACC_W-1:0]   norm_sq
);

  localparam int unsigned    CNT_W    = LOGN + 32'd1;
  localparam logic [CNT_W-1:0] LAST_IDX = {CNT_W{1'b1}};

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_drain;
  logic [ACC_W-1:0]   r_acc;
  logic               r_range_acc;

  logic               w_accept;
  logic               w_clear;
  logic               w_s1_valid;
  logic [SQ_W-1:0]    w_s1_sq;
  logic               w_s1_bad;

  // A coefficient is taken only while collecting and not being abandoned
  assign w_accept = (r_state == ST_COLLECT) && f_valid && !abort;
  assign w_clear  = (r_state == ST_IDLE) && start;

  // Stage 1: square and range flag
  poly_coeff_sq_range #(
    .MAX_BITS (MAX_BITS)
  ) u_sq_range (
    .clk         (clk),
    .rst         (rst),
    .i_valid     (w_accept),
    .i_coeff     (f),
    .o_valid     (w_s1_valid),
    .o_sq        (w_s1_sq),
    .o_range_bad (w_s1_bad)
  );

  // Stage 2: joint norm accumulation and sticky range flag; start wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc       <= '0;
      r_range_acc <= 1'b0;
    end else if (w_clear) begin
      r_acc       <= '0;
      r_range_acc <= 1'b0;
    end else if (w_s1_valid) begin
      r_acc       <= r_acc + ACC_W'(w_s1_sq);
      r_range_acc <= r_range_acc | w_s1_bad;
    end
  end

  // Control FSM with buffer write port and verdict registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_drain   <= 1'b0;
      gen_ena   <= 1'b0;
      buf_we    <= 1'b0;
      buf_addr  <= '0;
      buf_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ok        <= 1'b0;
      range_err <= 1'b0;
      norm_sq   <= '0;
    end else begin
      done   <= 1'b0;
      buf_we <= w_accept;
      if (w_accept) begin
        buf_addr  <= r_cnt;
        buf_wdata <= f;
      end

      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state   <= ST_COLLECT;
            r_cnt     <= '0;
            gen_ena   <= 1'b1;
            busy      <= 1'b1;
            ok        <= 1'b0;
            range_err <= 1'b0;
            norm_sq   <= '0;
          end
        end

        ST_COLLECT: begin
          if (abort) begin
            r_state <= ST_IDLE;
            gen_ena <= 1'b0;
            busy    <= 1'b0;
          end else if (f_valid) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == LAST_IDX) begin
              r_state <= ST_FINISH;
              r_drain <= 1'b0;
              gen_ena <= 1'b0;
            end
          end
        end

        // Two drain cycles let the last coefficient pass stages 1 and 2
        ST_FINISH: begin
          if (abort) begin
            r_state <= ST_IDLE;
            busy    <= 1'b0;
          end else if (r_drain) begin
            r_state   <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b1;
            norm_sq   <= r_acc;
            range_err <= r_range_acc;
            ok        <= !r_range_acc && (r_acc < ACC_W'(NORM_BOUND));
          end else begin
            r_drain <= 1'b1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          gen_ena <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_poly_small_norm_check.sv
// ---------------------------------------------------------------------------
// tb_poly_small_norm_check
// Self-checking bench: directed and randomized f/g runs compared every cycle
// against a behavioural expectation built from the coefficient list.
// ---------------------------------------------------------------------------
module tb_poly_small_norm_check;

  localparam int LOGN  = 9;
  localparam int N2    = 2 << LOGN;   // 2n coefficients per run
  localparam int LIM   = 31;          // 2^(6-1)-1
  localparam int BOUND = 16823;
  localparam int BIG   = 1 << 30;

  logic        clk = 1'b0;
  logic        rst, start, abort, f_valid;
  logic [7:0]  f;
  logic        gen_ena, buf_we, busy, done, ok, range_err;
  logic [LOGN:0] buf_addr;
  logic [7:0]  buf_wdata;
  logic [31:0] norm_sq;

  poly_small_norm_check dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .f_valid   (f_valid),
    .f         (f),
    .gen_ena   (gen_ena),
    .buf_we    (buf_we),
    .buf_addr  (buf_addr),
    .buf_wdata (buf_wdata),
    .busy      (busy),
    .done      (done),
    .ok        (ok),
    .range_err (range_err),
    .norm_sq   (norm_sq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at_cyc;
    int         addr;
    logic [7:0] data;
  } wr_t;
  wr_t wq[$];

  int   coeff [0:N2-1];
  logic [7:0] shadow [0:N2-1];

  // Expected-behaviour windows (in posedge counts) and verdicts
  int g_lo = 0, g_hi = 0, b_lo = 0, b_hi = 0, done_at = -1, clr_at = -1;
  logic v_ok = 1'b0, v_rerr = 1'b0, h_ok = 1'b0, h_rerr = 1'b0;
  logic [31:0] v_norm = '0, h_norm = '0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the expectation windows and write queue
  always @(negedge clk) begin
    logic exp_we;
    if (cyc == clr_at) begin
      h_ok = 1'b0; h_rerr = 1'b0; h_norm = '0;
    end
    if (cyc == done_at) begin
      h_ok = v_ok; h_rerr = v_rerr; h_norm = v_norm;
    end
    chk("gen_ena",   32'(gen_ena),   32'(cyc >= g_lo && cyc < g_hi));
    chk("busy",      32'(busy),      32'(cyc >= b_lo && cyc < b_hi));
    chk("done",      32'(done),      32'(cyc == done_at));
    chk("ok",        32'(ok),        32'(h_ok));
    chk("range_err", 32'(range_err), 32'(h_rerr));
    chk("norm_sq",   norm_sq,        h_norm);
    exp_we = (wq.size() > 0) && (wq[0].at_cyc == cyc);
    chk("buf_we", 32'(buf_we), 32'(exp_we));
    if (exp_we) begin
      chk("buf_addr",  32'(buf_addr),  32'(wq[0].addr));
      chk("buf_wdata", 32'(buf_wdata), 32'(wq[0].data));
      void'(wq.pop_front());
    end
    while (wq.size() > 0 && wq[0].at_cyc < cyc) void'(wq.pop_front());
    if (buf_we === 1'b1 && !$isunknown(buf_addr)) shadow[buf_addr] = buf_wdata;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Verdict from the coefficient list: sum of squares, any |c| > LIM
  task automatic model_verdict();
    int nrm;
    logic bad;
    nrm = 0;
    bad = 1'b0;
    for (int i = 0; i < N2; i++) begin
      nrm += coeff[i] * coeff[i];
      if (coeff[i] > LIM || coeff[i] < -LIM) bad = 1'b1;
    end
    v_norm = 32'(nrm);
    v_rerr = bad;
    v_ok   = !bad && (nrm < BOUND);
  endtask

  // Start pulse, with a same-cycle f_valid that must be ignored
  task automatic do_start();
    tick();
    start = 1'b1; f_valid = 1'b1; f = 8'h7f;
    clr_at = cyc + 1; g_lo = cyc + 1; g_hi = BIG; b_lo = cyc + 1; b_hi = BIG; done_at = -1;
    tick();
    start = 1'b0; f_valid = 1'b0;
  endtask

  // gap < 0 selects a random 0..2 idle cycles before each coefficient
  task automatic send(input int cnt, input int gap);
    int g;
    int last_c;
    last_c = 0;
    for (int i = 0; i < cnt; i++) begin
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      repeat (g) begin f_valid = 1'b0; tick(); end
      f_valid = 1'b1;
      f = 8'(coeff[i]);
      wq.push_back('{at_cyc: cyc + 1, addr: i, data: 8'(coeff[i])});
      last_c = cyc;
      tick();
    end
    if (cnt == N2) begin
      g_hi = last_c + 1; b_hi = last_c + 3; done_at = last_c + 3;
      model_verdict();
      // Strobes arriving while draining or idle must be ignored
      repeat (3) begin f_valid = 1'b1; f = 8'($urandom); tick(); end
      f_valid = 1'b0;
      while (cyc <= done_at + 2) tick();
    end else begin
      f_valid = 1'b0;
    end
  endtask

  task automatic run_full(input int gap);
    do_start();
    send(N2, gap);
  endtask

  task automatic fill(input int v);
    for (int i = 0; i < N2; i++) coeff[i] = v;
  endtask

  task automatic fill_bound(input int k, input int m);
    fill(4);
    for (int i = 0; i < k; i++) coeff[i] = 5;
    for (int i = k; i < k + m; i++) coeff[i] = 3;
  endtask

  task automatic chk_verdict(input string tag, input int nrm, input logic o, input logic re);
    chk({tag, "_norm"}, norm_sq, 32'(nrm));
    chk({tag, "_ok"}, 32'(ok), 32'(o));
    chk({tag, "_rerr"}, 32'(range_err), 32'(re));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; f_valid = 1'b0; f = '0;
    tick();
    chk("rst_gen_ena", 32'(gen_ena), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_norm", norm_sq, 0);
    tick();
    rst = 1'b0;
    tick();

    // All +1
    fill(1);
    run_full(0);
    chk_verdict("ones", 1024, 1'b1, 1'b0);
    chk("ones_ram0", 32'(shadow[0]), 32'h01);
    chk("ones_ram_last", 32'(shadow[N2-1]), 32'h01);

    // All -4, then all -5
    fill(-4);
    run_full(0);
    chk_verdict("m4", 16384, 1'b1, 1'b0);
    fill(-5);
    run_full(0);
    chk_verdict("m5", 25600, 1'b0, 1'b0);

    // Single out-of-range coefficient
    fill(0); coeff[700] = 32;
    run_full(0);
    chk_verdict("p32", 1024, 1'b0, 1'b1);
    chk("p32_ram700", 32'(shadow[700]), 32'h20);
    fill(0); coeff[700] = -128;
    run_full(0);
    chk_verdict("m128", 16384, 1'b0, 1'b1);
    chk("m128_ram700", 32'(shadow[700]), 32'h80);

    // Sparse strobes, alternating +2/-2
    for (int i = 0; i < N2; i++) coeff[i] = (i % 2 == 0) ? 2 : -2;
    run_full(2);
    chk_verdict("sparse", 4096, 1'b1, 1'b0);

    // Norm exactly at the bound rejects, one below accepts
    fill_bound(55, 8);
    run_full(0);
    chk_verdict("at_bound", 16823, 1'b0, 1'b0);
    fill_bound(51, 3);
    run_full(0);
    chk_verdict("below_bound", 16822, 1'b1, 1'b0);

    // Abort after 500 coefficients, then a full run from address 0
    fill(1);
    do_start();
    send(500, 0);
    abort = 1'b1;
    g_hi = cyc + 1; b_hi = cyc + 1;
    tick();
    abort = 1'b0;
    repeat (10) tick();
    run_full(0);
    chk_verdict("post_abort", 1024, 1'b1, 1'b0);

    // Asynchronous reset mid-run
    fill(3);
    do_start();
    send(300, 0);
    rst = 1'b1;
    wq.delete();
    g_lo = 0; g_hi = 0; b_lo = 0; b_hi = 0; done_at = -1; clr_at = -1;
    h_ok = 1'b0; h_rerr = 1'b0; h_norm = '0;
    #1;
    chk("arst_gen_ena", 32'(gen_ena), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_buf_we", 32'(buf_we), 0);
    chk("arst_buf_addr", 32'(buf_addr), 0);
    chk("arst_wdata", 32'(buf_wdata), 0);
    tick(); tick();
    rst = 1'b0;
    repeat (5) begin f_valid = 1'b1; f = 8'h11; tick(); end
    f_valid = 1'b0;
    fill(1);
    run_full(0);
    chk_verdict("post_rst", 1024, 1'b1, 1'b0);

    // Randomized runs with random strobe gaps
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < N2; i++) begin
        int p;
        p = int'($urandom_range(0, 999));
        if (p < 2)       coeff[i] = -128;
        else if (p < 10) coeff[i] = int'($urandom_range(0, 80)) - 40;
        else             coeff[i] = int'($urandom_range(0, 12)) - 6;
      end
      run_full(-1);
    end

    chk("write_queue_drained", 32'(wq.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
